tx_stage: RTL and testbench

//   Return path of the coprocessor: accepts ALU results (opcode echo + 16-bit result)

---
 rtl/tx_stage.sv | 138 +++++++++++++
 tb/tb_tx_stage.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_stage.sv
// Result return path: buffers ALU results in a small FIFO and serializes each as a byte frame.
// Define TX_CHECKSUM_EN to append an XOR checksum byte (4-byte frames instead of 3).
module tx_stage #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [7:0]  res_op,
  input  logic [15:0] res_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StSendOp,
    StSendHi,
`ifdef TX_CHECKSUM_EN
    StSendLo,
    StSendCk
`else
    StSendLo
`endif
  } state_e;

  state_e        state_q, state_d;
  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   frame_q, frame_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic [23:0]   head;
  logic          push, pop, last_done;

  assign head      = mem_q[rd_ptr_q];
  assign res_ready = (count_q < DepthC);
  assign push      = res_valid && res_ready;
  // The head slot is freed as soon as the opcode byte is taken; frame_q keeps the rest.
  assign pop       = (state_q == StSendOp) && tx_ready;
  assign tx_valid  = (state_q != StIdle);
  assign tx_data   = tx_data_q;
  assign tx_busy   = (state_q != StIdle) || (count_q != '0);

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    tx_data_d = tx_data_q;
    last_done = 1'b0;
    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          state_d   = StSendOp;
          frame_d   = head;
          tx_data_d = head[23:16];
        end
      end
      StSendOp: begin
        if (tx_ready) begin
          state_d   = StSendHi;
          tx_data_d = frame_q[15:8];
        end
      end
      StSendHi: begin
        if (tx_ready) begin
          state_d   = StSendLo;
          tx_data_d = frame_q[7:0];
        end
      end
      StSendLo: begin
        if (tx_ready) begin
`ifdef TX_CHECKSUM_EN
          state_d   = StSendCk;
          tx_data_d = frame_q[23:16] ^ frame_q[15:8] ^ frame_q[7:0];
`else
          last_done = 1'b1;
`endif
        end
      end
`ifdef TX_CHECKSUM_EN
      StSendCk: begin
        if (tx_ready) last_done = 1'b1;
      end
`endif
      default: state_d = StIdle;
    endcase

    // Chain straight into the next frame when one is already queued.
    if (last_done) begin
      if (count_q != '0) begin
        state_d   = StSendOp;
        frame_d   = head;
        tx_data_d = head[23:16];
      end else begin
        state_d = StIdle;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      frame_q   <= '0;
      tx_data_q <= 8'h00;
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      tx_data_q <= tx_data_d;
      count_q   <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {res_op, res_data};
  end

endmodule

// File: tb/tb_tx_stage.sv
// Self-checking bench for tx_stage: scoreboard of expected frame bytes plus per-scenario checks.
// Build with TX_CHECKSUM_EN defined to exercise the 4-byte frame variant.
module tb_tx_stage;

`ifdef TX_CHECKSUM_EN
  localparam int FrameLen = 4;
`else
  localparam int FrameLen = 3;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_op;
  logic [15:0] res_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        tx_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int n_rx     = 0;
  logic [7:0] sb [$];

  tx_stage #(.DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_op    (res_op),
    .res_data  (res_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  // Monitor: byte order against the scoreboard and handshake stability while stalled.
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
          n_fail++;
          $display("FAIL stall_hold: tx_valid=%b tx_data=%h, required 1 and %h",
                   tx_valid, tx_data, prev_data);
        end
      end
      if (tx_valid && tx_ready) begin
        n_checks++;
        n_rx++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL tx_byte: unexpected byte %h, no byte expected", tx_data);
        end else begin
          exp_b = sb.pop_front();
          if (tx_data !== exp_b) begin
            n_fail++;
            $display("FAIL tx_byte: got %h, required %h", tx_data, exp_b);
          end
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  // Stimulus helper: present a result until accepted, recording its frame bytes.
  task automatic push_res(input logic [7:0] op, input logic [15:0] d);
    bit ok = 1'b0;
    res_valid = 1'b1;
    res_op    = op;
    res_data  = d;
    for (int n = 0; n < 200 && !ok; n++) begin
      if (res_ready) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    res_valid = 1'b0;
    if (ok) begin
      sb.push_back(op);
      sb.push_back(d[15:8]);
      sb.push_back(d[7:0]);
`ifdef TX_CHECKSUM_EN
      sb.push_back(op ^ d[15:8] ^ d[7:0]);
`endif
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: res_ready stayed 0, required 1 within 200 cycles");
    end
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      if (sb.size() == 0 && !tx_busy) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL drain: %0d bytes pending tx_busy=%b, required 0 and 0", sb.size(), tx_busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; res_valid = 1'b0; res_op = '0; res_data = '0; tx_ready = 1'b0;
    #13;
    n_checks++;
    if (tx_valid !== 1'b0 || tx_data !== 8'h00 || tx_busy !== 1'b0 || res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_vals: valid=%b data=%h busy=%b ready=%b, required 0 00 0 1",
               tx_valid, tx_data, tx_busy, res_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    tx_ready = 1'b1;
    push_res(8'h01, 16'hBEEF);
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: tx_valid=%b one cycle after push, required 0", tx_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h01) begin
      n_fail++;
      $display("FAIL latency_b0: valid=%b data=%h, required 1 01", tx_valid, tx_data);
    end
    @(posedge clk); #1;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hBE) begin
      n_fail++;
      $display("FAIL single_b1: valid=%b data=%h, required 1 BE", tx_valid, tx_data);
    end
    @(posedge clk); #1;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'hEF) begin
      n_fail++;
      $display("FAIL single_b2: valid=%b data=%h, required 1 EF", tx_valid, tx_data);
    end
`ifdef TX_CHECKSUM_EN
    @(posedge clk); #1;
    n_checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h50) begin
      n_fail++;
      $display("FAIL single_ck: valid=%b data=%h, required 1 50", tx_valid, tx_data);
    end
`endif
    wait_idle();
  endtask

  task automatic test_stall_hi();
    tx_ready = 1'b0;
    push_res(8'h02, 16'hBE34);
    for (int n = 0; n < 10 && !tx_valid; n++) begin
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      n_checks++;
      if (tx_valid !== 1'b1 || tx_data !== 8'hBE) begin
        n_fail++;
        $display("FAIL stall_hi[%0d]: valid=%b data=%h, required 1 BE", n, tx_valid, tx_data);
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_fill();
    int rx0;
    rx0 = n_rx;
    tx_ready = 1'b0;
    push_res(8'h11, 16'hA1B2);
    push_res(8'h22, 16'hC3D4);
    res_valid = 1'b1; res_op = 8'h33; res_data = 16'hE5F6;
    for (int n = 0; n < 3; n++) begin
      n_checks++;
      if (res_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL fill_ready[%0d]: res_ready=%b, required 0", n, res_ready);
      end
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    push_res(8'h33, 16'hE5F6);
    wait_idle();
    n_checks++;
    if (n_rx - rx0 != 3 * FrameLen) begin
      n_fail++;
      $display("FAIL fill_count: %0d bytes, required %0d", n_rx - rx0, 3 * FrameLen);
    end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    bit seen = 1'b0;
    bit stop = 1'b0;
    tx_ready = 1'b1;
    push_res(8'h44, 16'h1234);
    push_res(8'h55, 16'h5678);
    for (int n = 0; n < 40 && !stop; n++) begin
      if (tx_valid) begin
        seen = 1'b1;
        run++;
      end else if (seen) begin
        stop = 1'b1;
      end
      if (!stop) begin
        @(posedge clk); #1;
      end
    end
    n_checks++;
    if (run != 2 * FrameLen) begin
      n_fail++;
      $display("FAIL b2b_run: %0d contiguous valid cycles, required %0d", run, 2 * FrameLen);
    end
    n_checks++;
    if (tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_busy: tx_busy=%b after last byte, required 0", tx_busy);
    end
    wait_idle();
  endtask

  task automatic test_reset_midframe();
    tx_ready = 1'b0;
    push_res(8'h66, 16'h9ABC);
    push_res(8'h77, 16'hDEF0);
    for (int n = 0; n < 10 && !tx_valid; n++) begin
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(posedge clk); #1;
    tx_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: tx_valid=%b during reset, required 0", tx_valid);
    end
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_checks++;
    if (res_ready !== 1'b1 || tx_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: res_ready=%b tx_busy=%b, required 1 0", res_ready, tx_busy);
    end
    tx_ready = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      n_checks++;
      if (tx_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_stale[%0d]: tx_valid=%b, required 0", n, tx_valid);
      end
    end
  endtask

  task automatic test_full_pop();
    tx_ready = 1'b0;
    push_res(8'h88, 16'h0102);
    push_res(8'h99, 16'h0304);
    for (int n = 0; n < 10 && !tx_valid; n++) begin
      @(posedge clk); #1;
    end
    res_valid = 1'b1; res_op = 8'hAA; res_data = 16'h0506;
    tx_ready  = 1'b1;
    n_checks++;
    if (res_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_ready: res_ready=%b with pop pending, required 0", res_ready);
    end
    @(posedge clk); #1;
    n_checks++;
    if (res_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL full_pop_next: res_ready=%b after pop, required 1", res_ready);
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
    sb.push_back(8'hAA); sb.push_back(8'h05); sb.push_back(8'h06);
`ifdef TX_CHECKSUM_EN
    sb.push_back(8'hAA ^ 8'h05 ^ 8'h06);
`endif
    n_checks++;
    if (res_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full_pop_accept: res_ready=%b after refill, required 0", res_ready);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_hi();
    test_fill();
    test_back_to_back();
    test_reset_midframe();
    test_full_pop();
    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
